// File: rtl/emissor_caminho.sv
// emissor_caminho
// Buffers path nodes, which arrive destination first, in a LIFO and
// re-emits them source first on a valid/ready stream. The last word of
// the path carries an end marker. The block also reports the stored
// length, a busy flag and a sticky overflow flag.
module emissor_caminho #(
  parameter int ADDR_WIDTH  = 8,
  parameter int MAX_CAMINHO = 64,
  parameter int CNT_WIDTH   = $clog2(MAX_CAMINHO + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  no_valid_in,
  input  logic [ADDR_WIDTH-1:0] no_addr_in,
  input  logic                  no_ultimo_in,
  input  logic                  saida_ready_in,
  output logic                  saida_valid_out,
  output logic [ADDR_WIDTH-1:0] saida_addr_out,
  output logic                  saida_ultimo_out,
  output logic [CNT_WIDTH-1:0]  tamanho_out,
  output logic                  ocupado_out,
  output logic                  overflow_out
);

  localparam int IDX_WIDTH = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_CAMINHO);
  localparam logic [CNT_WIDTH-1:0] CNT_UM  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CARGA   = 2'd1,
    EMISSAO = 2'd2
  } estado_t;

  estado_t estado;
  estado_t prox_estado;

  logic [ADDR_WIDTH-1:0] mem [MAX_CAMINHO];
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  overflow_q;

  logic                  push;
  logic                  cheio;
  logic                  grava;
  logic                  inicio;
  logic                  fim_carga;
  logic                  overflow_caminho;
  logic                  descarta;
  logic                  pop;
  logic                  ultimo_pop;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [IDX_WIDTH-1:0]  rd_idx;

  // Nodes are only taken while not emitting; upstream is expected to gate on
  // ocupado_out, so anything offered during emission is simply ignored.
  assign push      = no_valid_in && (estado != EMISSAO);
  assign cheio     = (cnt == CNT_MAX);
  assign grava     = push && !cheio;
  assign inicio    = push && (estado == OCIOSO);
  assign fim_carga = push && no_ultimo_in;

  // A push from OCIOSO starts a fresh path, so any stale sticky flag from a
  // previously discarded path does not count against it. A drop on the very
  // push that carries the end marker still counts.
  assign overflow_caminho = cheio || (overflow_q && !inicio);
  assign descarta         = fim_carga && overflow_caminho;

  assign pop        = (estado == EMISSAO) && saida_ready_in;
  assign ultimo_pop = pop && (cnt == CNT_UM);

  assign wr_idx = IDX_WIDTH'(cnt);
  assign rd_idx = IDX_WIDTH'(cnt - CNT_UM);

  // State register; reset drops any path being loaded or emitted.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      estado <= OCIOSO;
    end else begin
      estado <= prox_estado;
    end
  end

  // Next-state decision: load until the source node arrives, then emit
  // unless the path overflowed, and go idle after the final handshake.
  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO: begin
        if (push) begin
          if (no_ultimo_in) begin
            prox_estado = descarta ? OCIOSO : EMISSAO;
          end else begin
            prox_estado = CARGA;
          end
        end
      end
      CARGA: begin
        if (fim_carga) begin
          prox_estado = descarta ? OCIOSO : EMISSAO;
        end
      end
      EMISSAO: begin
        if (ultimo_pop) begin
          prox_estado = OCIOSO;
        end
      end
      default: begin
        prox_estado = OCIOSO;
      end
    endcase
  end

  // Output decode: the stream is only driven while emitting, and the top of
  // the LIFO is presented directly so it holds steady under backpressure.
  always_comb begin
    saida_valid_out  = 1'b0;
    saida_addr_out   = '0;
    saida_ultimo_out = 1'b0;
    if (estado == EMISSAO) begin
      saida_valid_out  = 1'b1;
      saida_addr_out   = mem[rd_idx];
      saida_ultimo_out = (cnt == CNT_UM);
    end
  end

  // Occupancy counter: grows on accepted pushes, shrinks on handshakes and
  // is cleared outright when an overflowed path is abandoned.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
    end else if (descarta) begin
      cnt <= '0;
    end else if (grava) begin
      cnt <= cnt + CNT_UM;
    end else if (pop) begin
      cnt <= cnt - CNT_UM;
    end
  end

  // Sticky overflow: set by a dropped node and cleared only when the next
  // path starts, so the top level can still see why nothing was emitted.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      overflow_q <= 1'b0;
    end else if (push) begin
      if (cheio) begin
        overflow_q <= 1'b1;
      end else if (inicio) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // LIFO storage; contents need no reset because cnt marks what is valid.
  always_ff @(posedge clk) begin
    if (grava) begin
      mem[wr_idx] <= no_addr_in;
    end
  end

  assign tamanho_out  = cnt;
  assign ocupado_out  = (estado != OCIOSO);
  assign overflow_out = overflow_q;

endmodule

// File: tb/tb_emissor_caminho.sv
// tb_emissor_caminho
// Directed bench for emissor_caminho: normal path, backpressure,
// single-node path, overflow, reset mid-emission and ignored pushes.
module tb_emissor_caminho;

  localparam int ADDR_WIDTH  = 8;
  localparam int MAX_CAMINHO = 64;
  localparam int CNT_WIDTH   = $clog2(MAX_CAMINHO + 1);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  no_valid_in;
  logic [ADDR_WIDTH-1:0] no_addr_in;
  logic                  no_ultimo_in;
  logic                  saida_ready_in;
  logic                  saida_valid_out;
  logic [ADDR_WIDTH-1:0] saida_addr_out;
  logic                  saida_ultimo_out;
  logic [CNT_WIDTH-1:0]  tamanho_out;
  logic                  ocupado_out;
  logic                  overflow_out;

  int errors = 0;
  int checks = 0;

  int path_in  [0:7];
  int path_out [0:7];
  bit saw_valid;

  emissor_caminho #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_CAMINHO(MAX_CAMINHO),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .no_valid_in     (no_valid_in),
    .no_addr_in      (no_addr_in),
    .no_ultimo_in    (no_ultimo_in),
    .saida_ready_in  (saida_ready_in),
    .saida_valid_out (saida_valid_out),
    .saida_addr_out  (saida_addr_out),
    .saida_ultimo_out(saida_ultimo_out),
    .tamanho_out     (tamanho_out),
    .ocupado_out     (ocupado_out),
    .overflow_out    (overflow_out)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input int addr, input logic ultimo, input logic ready);
    no_valid_in    = valid;
    no_addr_in     = ADDR_WIDTH'(addr);
    no_ultimo_in   = ultimo;
    saida_ready_in = ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"},   32'(saida_valid_out), 32'd0);
    checkOutput({tag, "_addr"},    32'(saida_addr_out), 32'd0);
    checkOutput({tag, "_ocupado"}, 32'(ocupado_out), 32'd0);
    checkOutput({tag, "_tamanho"}, 32'(tamanho_out), 32'd0);
  endtask

  // Push path_in[0..n-1], end marker on the last one, ready held high.
  task automatic loadPath(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, path_in[i], (i == n - 1), 1'b1);
      step();
      checkOutput("load_tamanho", 32'(tamanho_out), 32'(i + 1));
      if (i < n - 1) begin
        checkOutput("load_valid", 32'(saida_valid_out), 32'd0);
        checkOutput("load_ocupado", 32'(ocupado_out), 32'd1);
      end
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
  endtask

  // Expect path_out[0..n-1] on consecutive cycles, optionally stalling at
  // one word and offering a stray node (addr 99, ready low) at another.
  task automatic emitPath(input int n, input int stall_at, input int stall_n, input int inject_at);
    for (int i = 0; i < n; i++) begin
      checkOutput("emit_valid", 32'(saida_valid_out), 32'd1);
      checkOutput("emit_addr", 32'(saida_addr_out), 32'(path_out[i]));
      checkOutput("emit_ultimo", 32'(saida_ultimo_out), 32'(i == n - 1));
      checkOutput("emit_tamanho", 32'(tamanho_out), 32'(n - i));
      if (i == stall_at) begin
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        for (int s = 0; s < stall_n; s++) begin
          step();
          checkOutput("hold_valid", 32'(saida_valid_out), 32'd1);
          checkOutput("hold_addr", 32'(saida_addr_out), 32'(path_out[i]));
          checkOutput("hold_ultimo", 32'(saida_ultimo_out), 32'(i == n - 1));
          checkOutput("hold_tamanho", 32'(tamanho_out), 32'(n - i));
        end
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
      end
      if (i == inject_at) begin
        applyStimulus(1'b1, 99, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkOutput("inject_addr", 32'(saida_addr_out), 32'(path_out[i]));
        checkOutput("inject_tamanho", 32'(tamanho_out), 32'(n - i));
      end
      step();
    end
    checkOutput("end_valid", 32'(saida_valid_out), 32'd0);
    checkOutput("end_ocupado", 32'(ocupado_out), 32'd0);
    checkOutput("end_tamanho", 32'(tamanho_out), 32'd0);
  endtask

  // Directed sequence covering every scenario in order.
  initial begin
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    #1;
    checkIdle("reset");
    checkOutput("reset_overflow", 32'(overflow_out), 32'd0);
    step();
    step();
    rst_n = 1'b0;
    step();

    $display("[TB] basic 5-node path");
    path_in  = '{40, 33, 21, 9, 0, 0, 0, 0};
    path_out = '{0, 9, 21, 33, 40, 0, 0, 0};
    loadPath(5);
    emitPath(5, -1, 0, -1);

    $display("[TB] backpressure on 21");
    loadPath(5);
    emitPath(5, 2, 3, -1);

    $display("[TB] single-node path");
    path_in  = '{7, 0, 0, 0, 0, 0, 0, 0};
    path_out = '{7, 0, 0, 0, 0, 0, 0, 0};
    loadPath(1);
    emitPath(1, -1, 0, -1);

    $display("[TB] overflow with 65 nodes");
    saw_valid = 1'b0;
    for (int i = 0; i < 65; i++) begin
      applyStimulus(1'b1, i, (i == 64), 1'b1);
      step();
      if (saida_valid_out) saw_valid = 1'b1;
      if (i == 63) begin
        checkOutput("ovf_full_tamanho", 32'(tamanho_out), 32'd64);
        checkOutput("ovf_full_flag", 32'(overflow_out), 32'd0);
      end
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput("ovf_flag", 32'(overflow_out), 32'd1);
    checkIdle("ovf_abort");
    step();
    if (saida_valid_out) saw_valid = 1'b1;
    checkOutput("ovf_sticky", 32'(overflow_out), 32'd1);
    checkOutput("ovf_never_valid", 32'(saw_valid), 32'd0);

    path_in  = '{11, 12, 13, 0, 0, 0, 0, 0};
    path_out = '{13, 12, 11, 0, 0, 0, 0, 0};
    applyStimulus(1'b1, path_in[0], 1'b0, 1'b1);
    step();
    checkOutput("ovf_clear_flag", 32'(overflow_out), 32'd0);
    checkOutput("ovf_clear_tamanho", 32'(tamanho_out), 32'd1);
    applyStimulus(1'b1, path_in[1], 1'b0, 1'b1);
    step();
    applyStimulus(1'b1, path_in[2], 1'b1, 1'b1);
    step();
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    emitPath(3, -1, 0, -1);

    $display("[TB] back-to-back push right after completion");
    path_in  = '{5, 0, 0, 0, 0, 0, 0, 0};
    path_out = '{5, 0, 0, 0, 0, 0, 0, 0};
    loadPath(1);
    emitPath(1, -1, 0, -1);
    loadPath(1);
    emitPath(1, -1, 0, -1);

    $display("[TB] reset during emission");
    path_in  = '{40, 33, 21, 9, 0, 0, 0, 0};
    loadPath(5);
    checkOutput("rst_first", 32'(saida_addr_out), 32'd0);
    step();
    checkOutput("rst_second", 32'(saida_addr_out), 32'd9);
    rst_n = 1'b1;
    #1;
    checkIdle("rst_async");
    step();
    checkIdle("rst_hold");
    #1;
    rst_n = 1'b0;
    step();
    checkIdle("rst_release");
    path_in  = '{1, 2, 3, 0, 0, 0, 0, 0};
    path_out = '{3, 2, 1, 0, 0, 0, 0, 0};
    loadPath(3);
    emitPath(3, -1, 0, -1);

    $display("[TB] stray push during emission");
    loadPath(3);
    emitPath(3, -1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/emissor_caminho.md
# emissor_caminho

Downstream stage of `gerenciador_memoria_anterior`. That stage backtracks the predecessor memory and delivers the shortest path one node per cycle, destination first. This block buffers the nodes in a LIFO and re-emits them source first over a valid/ready stream with an end-of-path marker. It also reports path length, busy and overflow status to the top level.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: node address width; matches `ADDR_WIDTH` of `top`.
- `MAX_CAMINHO`, 64: LIFO depth, i.e. the maximum number of nodes in a path.
- `CNT_WIDTH`, $clog2(MAX_CAMINHO+1): width of the occupancy counter.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset rst_n, asynchronous, active-high.
- `no_valid_in`, in, 1: a path node is present on `no_addr_in` this cycle.
- `no_addr_in`, in, ADDR_WIDTH: node address, delivered destination first.
- `no_ultimo_in`, in, 1: qualified by `no_valid_in`; this node is the source, i.e. the last node of the path.
- `saida_ready_in`, in, 1: consumer accepts the output word.
- `saida_valid_out`, out, 1: output word valid.
- `saida_addr_out`, out, ADDR_WIDTH: node address, delivered source first.
- `saida_ultimo_out`, out, 1: the current output word is the destination (last word of the path).
- `tamanho_out`, out, CNT_WIDTH: number of nodes currently stored.
- `ocupado_out`, out, 1: block is not in OCIOSO.
- `overflow_out`, out, 1: sticky flag; the current path exceeded `MAX_CAMINHO`.

## Operation
- Storage is a register array `mem[MAX_CAMINHO]` plus a counter `cnt`; `tamanho_out = cnt`. Array contents are not reset.
- States are OCIOSO, CARGA and EMISSAO; `ocupado_out = (estado != OCIOSO)`.
- **Push rule (OCIOSO or CARGA, `no_valid_in`=1):**
  - If `cnt < MAX_CAMINHO`: write `mem[cnt] <= no_addr_in`, then `cnt <= cnt+1`.
  - Otherwise: drop the node, leave `cnt` unchanged, set `overflow_out <= 1`.
- **Leaving OCIOSO:** a push without `no_ultimo_in` goes to CARGA and clears `overflow_out` at the same edge.
- **Last node:** a push with `no_ultimo_in`=1 (from OCIOSO or CARGA) stores the node first, then:
  - goes to EMISSAO if no overflow occurred, including overflow on this same push;
  - otherwise returns to OCIOSO and sets `cnt <= 0`; nothing is emitted.
- **EMISSAO:**
  - `saida_valid_out` = 1.
  - `saida_addr_out = mem[cnt-1]`.
  - `saida_ultimo_out = (cnt == 1)`.
  - Each cycle with `saida_valid_out && saida_ready_in` pops one entry: `cnt <= cnt-1`.
  - The pop of the word with `saida_ultimo_out`=1 returns the block to OCIOSO with `cnt` = 0.
- `no_valid_in` during EMISSAO is ignored: no write, no change to `cnt`. Upstream gates on `ocupado_out`.
- **Single-node path** (fonte == destino): one valid push with `no_ultimo_in`=1 yields exactly one output word with `saida_ultimo_out`=1.
- Outside EMISSAO, `saida_valid_out`, `saida_addr_out` and `saida_ultimo_out` are forced to 0.

## Timing
- **Reset (asynchronous):**
  - `estado` = OCIOSO, `cnt` = 0, `overflow_out` = 0.
  - All outputs read 0 immediately, without waiting for a clock edge.
  - Reset mid-CARGA or mid-EMISSAO discards the path with no partial emission after release.
- **Latency:** `saida_valid_out` rises in the cycle immediately after the edge that captured the `no_ultimo_in` push.
- **Throughput:** one word per cycle while `saida_ready_in`=1. A path of N nodes completes N cycles after the first valid output, given no backpressure.
- **Backpressure:** while `saida_ready_in`=0, `saida_addr_out`, `saida_ultimo_out` and `saida_valid_out` hold stable. Valid never drops without a handshake.
- **Status outputs:** `tamanho_out` updates at the same edge as the push or pop. `overflow_out` is registered and visible the cycle after the offending push.
- **Back-to-back paths:** a new push is accepted in the cycle `ocupado_out` returns to 0, i.e. the cycle after the final handshake.

## Test plan
- Pushes 40, 33, 21, 9, then 0 with ultimo, on consecutive cycles, `saida_ready_in`=1:
  - outputs are 0, 9, 21, 33, 40 on consecutive cycles;
  - `saida_ultimo_out`=1 only on 40;
  - first valid output one cycle after the 0 push;
  - `tamanho_out` counts 1→5 during load and 5→0 during emission.
- Same path with `saida_ready_in`=0 for 3 cycles while 21 is presented: 21 holds for 4 cycles, no word is lost or duplicated, `tamanho_out` stays at 3.
- Single push of addr 7 with ultimo: exactly one output, 7, with `saida_ultimo_out`=1; `ocupado_out` returns to 0 the cycle after the handshake.
- `MAX_CAMINHO`=64, 65 pushes with ultimo on the 65th:
  - `overflow_out`=1, `saida_valid_out` never asserts, block returns to OCIOSO with `tamanho_out`=0;
  - the next push clears `overflow_out`, and a following 3-node path emits correctly.
- Assert `rst_n` while the second word of a 5-node path is presented: outputs and `tamanho_out` go to 0 immediately; after release, a fresh path of 1, 2, 3(ultimo) emits 3, 2, 1.
- Pulse `no_valid_in` with addr 99 during EMISSAO: 99 never appears on the output, `tamanho_out` is unaffected, and the emitted sequence is unchanged.
